sram_fifo: RTL and testbench
============================

Name: sram_fifo

Overview:
- Ready/valid FIFO controller that drives one sram_r1_w1_rw0 instance as its storage array.
- Enqueue side writes through the SRAM write port.
- Dequeue side issues prefetch reads and absorbs the SRAM's one-cycle registered read latency in a 2-entry output skid buffer, so the consumer sees show-ahead data at full throughput.
- Used wherever a DANA unit needs a deep queue (e.g. PE result buffering) without flop-based storage.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 64, SRAM entries; must be a power of two, at least 2.
- LG_DEPTH, 6, log2(DEPTH).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- io_enq_valid  input  1  producer has data.
- io_enq_ready  output  1  FIFO accepts data this cycle.
- io_enq_bits  input  WIDTH  enqueue data.
- io_deq_valid  output  1  io_deq_bits holds the head entry.
- io_deq_ready  input  1  consumer takes the head entry.
- io_deq_bits  output  WIDTH  head entry, show-ahead.
- io_count  output  LG_DEPTH+2  total entries held (SRAM + in-flight + skid).

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high: sampled only at the clk rising edge, asserted high.
- Reset clears wr_ptr, rd_ptr, sram_cnt, inflight, skid occupancy (occ) and skid data valid bits.
  - Outputs during reset and the first cycle after: io_enq_ready=0 while reset is high, then 1; io_deq_valid=0; io_count=0.
  - SRAM contents are not cleared; stale data is never exposed.
- Enqueue fire = io_enq_valid & io_enq_ready.
  - io_enq_ready = !reset & (sram_cnt < DEPTH).
  - On fire: weW=1, addrW=wr_ptr, dinW=io_enq_bits; wr_ptr increments modulo DEPTH (natural LG_DEPTH-bit wrap).
- Read issue (rd_issue): asserted when sram_cnt > 0 and (occ + inflight - deq_fire) < 2.
  - Drives addrR=rd_ptr; rd_ptr increments modulo DEPTH.
  - inflight is set next cycle.
- sram_cnt update: sram_cnt_next = sram_cnt + enq_fire - rd_issue. sram_cnt is LG_DEPTH+1 bits, range 0..DEPTH.
- No read-during-write hazard: rd_issue uses the registered sram_cnt, so an entry written in cycle t is first readable in cycle t+1.
- SRAM read data is valid on doutR in the cycle after rd_issue. It is pushed into the skid tail at the end of that cycle, and inflight clears.
- Skid buffer is 2 entries, in-order. Head drives io_deq_bits; io_deq_valid = (occ > 0).
- Dequeue fire = io_deq_valid & io_deq_ready: pops the head.
  - Simultaneous pop and push is allowed in the same cycle.
  - The occupancy bound guarantees occ never exceeds 2.
- io_count = sram_cnt + inflight + occ. Total capacity is DEPTH+2; io_enq_ready depends on sram_cnt only.
- Latency: enq fire in cycle t into an empty FIFO → rd_issue in t+1 → skid push at end of t+2 → io_deq_valid high in cycle t+3.
- Throughput: one enq and one deq per cycle sustained in steady state. Back-to-back reads are issued while the consumer drains.
- Simultaneous enq and deq at full: enq is blocked only by sram_cnt == DEPTH. A same-cycle rd_issue frees a slot from the next cycle, not combinationally.
- Reset mid-operation: all entries are discarded. A read in flight has its result dropped: no skid push in the cycle after reset.
- io_deq_bits is undefined while io_deq_valid=0. Implement it as the skid head register, not X-free muxing.

Decomposition:
- Shared package (dana_fifo_pkg):
  - SKID_DEPTH=2.
  - Function clog2.
  - A count-width helper (LG_DEPTH+2).
- Sub-module: one sram_r1_w1_rw0 instance, WIDTH/DEPTH/LG_DEPTH passed through.
- Control (pointers, counters, skid) stays in sram_fifo. No further split.

Test Plan:
- Reset, then enqueue one 0xA5 at cycle 0 with io_deq_ready=0 → io_deq_valid rises at cycle 3 with bits=0xA5; io_count=1 from cycle 1 onward.
- DEPTH=8: enqueue 0..11 with io_deq_ready=0.
  - io_enq_ready drops after the 10th accept (8 in SRAM + 2 in skid); io_count=10.
  - Then drain with ready=1: data 0..9 in order, one per cycle.
- Continuous enq and deq of an incrementing pattern for 200 cycles, DEPTH=8 → no bubbles after the initial 3-cycle fill; output equals input order across multiple pointer wraps.
- Random valid/ready (50% each), 5000 transfers → scoreboard matches; io_count never exceeds DEPTH+2; io_count equals the model occupancy every cycle.
- Full FIFO, assert io_enq_valid and io_deq_ready together → deq fires each cycle; enq accepted from the cycle after sram_cnt drops below DEPTH; no loss or duplication.
- Pulse reset for 1 cycle while 5 entries are stored and a read is in flight → next cycle io_deq_valid=0, io_count=0; a subsequent enqueue of 0x3C emerges at +3 cycles with no stale data.

Source files
------------

// File: rtl/dana_fifo_pkg.sv
// Shared constants and sizing helpers for the SRAM-backed DANA FIFOs.
package dana_fifo_pkg;

   localparam int unsigned SKID_DEPTH = 2;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   // io_count spans 0..DEPTH+SKID_DEPTH, so it needs two bits beyond the pointer width.
   function automatic int unsigned cnt_width(input int unsigned lg_depth);
      return lg_depth + 2;
   endfunction

endpackage

// File: rtl/sram_r1_w1_rw0.sv
// Simple dual-port SRAM: one synchronous write port, one read port with registered output.
module sram_r1_w1_rw0 #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned LG_DEPTH = 6
) (
   input  logic                clk,
   input  logic                reR,
   input  logic [LG_DEPTH-1:0] addrR,
   output logic [WIDTH-1:0]    doutR,
   input  logic                weW,
   input  logic [LG_DEPTH-1:0] addrW,
   input  logic [WIDTH-1:0]    dinW
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (weW) mem_q[addrW] <= dinW;
      if (reR) dout_q <= mem_q[addrR];
   end

   assign doutR = dout_q;

endmodule

// File: rtl/sram_fifo.sv
// Ready/valid FIFO storing entries in an SRAM; a 2-entry skid buffer hides the
// one-cycle read latency so the consumer sees show-ahead data at full rate.
module sram_fifo
   import dana_fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned LG_DEPTH = 6
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             io_enq_valid,
   output logic                             io_enq_ready,
   input  logic [WIDTH-1:0]                 io_enq_bits,
   output logic                             io_deq_valid,
   input  logic                             io_deq_ready,
   output logic [WIDTH-1:0]                 io_deq_bits,
   output logic [cnt_width(LG_DEPTH)-1:0]   io_count
);

   localparam int unsigned CntW   = LG_DEPTH + 1;
   localparam int unsigned CountW = cnt_width(LG_DEPTH);
   localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

   logic [LG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]     sram_cnt_q, sram_cnt_d;
   logic                inflight_q, inflight_d;
   logic [1:0]          occ_q, occ_d;
   logic [WIDTH-1:0]    skid_q [SKID_DEPTH];
   logic [WIDTH-1:0]    skid_d [SKID_DEPTH];

   logic             enq_fire, deq_fire, rd_issue, push;
   logic [1:0]       pending;
   logic [WIDTH-1:0] sram_dout;

   assign io_enq_ready = !reset && (sram_cnt_q < DepthCnt);
   assign io_deq_valid = (occ_q != 2'd0);
   assign io_deq_bits  = skid_q[0];
   assign io_count     = CountW'(sram_cnt_q) + CountW'(inflight_q) + CountW'(occ_q);

   assign enq_fire = io_enq_valid && io_enq_ready;
   assign deq_fire = io_deq_valid && io_deq_ready;
   assign push     = inflight_q;

   // Only issue a read when its data is guaranteed a free skid slot on arrival.
   assign pending  = occ_q + {1'b0, inflight_q} - {1'b0, deq_fire};
   assign rd_issue = !reset && (sram_cnt_q != '0) && (pending < 2'(SKID_DEPTH));

   sram_r1_w1_rw0 #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .LG_DEPTH (LG_DEPTH)
   ) u_sram (
      .clk   (clk),
      .reR   (rd_issue),
      .addrR (rd_ptr_q),
      .doutR (sram_dout),
      .weW   (enq_fire),
      .addrW (wr_ptr_q),
      .dinW  (io_enq_bits)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      inflight_d = rd_issue;
      occ_d      = occ_q;
      skid_d     = skid_q;
      sram_cnt_d = sram_cnt_q + CntW'(enq_fire) - CntW'(rd_issue);

      if (enq_fire) wr_ptr_d = wr_ptr_q + LG_DEPTH'(1);
      if (rd_issue) rd_ptr_d = rd_ptr_q + LG_DEPTH'(1);

      unique case ({deq_fire, push})
         2'b10: begin
            skid_d[0] = skid_q[1];
            occ_d     = occ_q - 2'd1;
         end
         2'b01: begin
            if (occ_q == 2'd0) skid_d[0] = sram_dout;
            else               skid_d[1] = sram_dout;
            occ_d = occ_q + 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               skid_d[0] = sram_dout;
            end else begin
               skid_d[0] = skid_q[1];
               skid_d[1] = sram_dout;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sram_cnt_q <= '0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         sram_cnt_q <= sram_cnt_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
      end
   end

   // Skid data needs no reset: occ_q alone decides what is visible.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

endmodule

// File: tb/tb_sram_fifo.sv
// Randomised and directed bench for sram_fifo; a negedge monitor scores every
// dequeue against a queue of accepted enqueues.
module tb_sram_fifo;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned DEPTH    = 8;
   localparam int unsigned LG_DEPTH = 3;
   localparam int          CAP      = DEPTH + 2;

   logic                clk;
   logic                reset;
   logic                enq_valid, enq_ready;
   logic [WIDTH-1:0]    enq_bits;
   logic                deq_valid, deq_ready;
   logic [WIDTH-1:0]    deq_bits;
   logic [LG_DEPTH+1:0] count;

   int checks = 0;
   int errors = 0;
   int n_deq  = 0;
   logic [WIDTH-1:0] model_q [$];

   sram_fifo #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .LG_DEPTH (LG_DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .io_enq_valid (enq_valid),
      .io_enq_ready (enq_ready),
      .io_enq_bits  (enq_bits),
      .io_deq_valid (deq_valid),
      .io_deq_ready (deq_ready),
      .io_deq_bits  (deq_bits),
      .io_count     (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      tick();
      reset = 1'b0;
      #1;
   endtask

   // Monitor: occupancy is entries accepted minus entries taken.
   always @(negedge clk) begin
      if (reset) begin
         model_q.delete();
         check("enq_ready_in_reset", int'(enq_ready), 0);
      end else begin
         check("count_vs_model", int'(count), model_q.size());
         check("count_bound", int'(int'(count) <= CAP), 1);
         if (enq_valid && enq_ready) model_q.push_back(enq_bits);
         if (deq_valid && deq_ready) begin
            n_deq++;
            if (model_q.size() == 0) check("deq_when_empty", int'(deq_valid), 0);
            else check("deq_data", int'(deq_bits), int'(model_q.pop_front()));
         end
      end
   end

   initial begin
      int idx, first, bubbles, stalls, misses, start;
      logic acc;

      reset     = 1'b1;
      enq_valid = 1'b0;
      enq_bits  = '0;
      deq_ready = 1'b0;
      repeat (2) tick();
      check("rst_enq_ready", int'(enq_ready), 0);
      check("rst_deq_valid", int'(deq_valid), 0);
      check("rst_count", int'(count), 0);
      reset = 1'b0;
      #1;
      check("post_rst_enq_ready", int'(enq_ready), 1);
      check("post_rst_deq_valid", int'(deq_valid), 0);
      check("post_rst_count", int'(count), 0);

      // Single-entry latency.
      do_reset();
      enq_valid = 1'b1;
      enq_bits  = 8'hA5;
      check("lat_c0_valid", int'(deq_valid), 0);
      tick();
      enq_valid = 1'b0;
      check("lat_c1_valid", int'(deq_valid), 0);
      check("lat_c1_count", int'(count), 1);
      tick();
      check("lat_c2_valid", int'(deq_valid), 0);
      check("lat_c2_count", int'(count), 1);
      tick();
      check("lat_c3_valid", int'(deq_valid), 1);
      check("lat_c3_bits", int'(deq_bits), 'hA5);
      deq_ready = 1'b1;
      tick();
      deq_ready = 1'b0;
      check("lat_after_valid", int'(deq_valid), 0);

      // Fill to capacity with the consumer stalled, then drain.
      do_reset();
      idx = 0;
      for (int c = 0; c < 30; c++) begin
         enq_valid = (idx < 12);
         enq_bits  = 8'(idx);
         acc       = enq_valid && enq_ready;
         tick();
         if (acc) idx++;
      end
      enq_valid = 1'b0;
      check("fill_accepts", idx, CAP);
      check("fill_enq_ready", int'(enq_ready), 0);
      check("fill_count", int'(count), CAP);
      deq_ready = 1'b1;
      for (int c = 0; c < CAP; c++) begin
         check("drain_valid", int'(deq_valid), 1);
         tick();
      end
      deq_ready = 1'b0;
      check("drain_empty_valid", int'(deq_valid), 0);
      check("drain_empty_count", int'(count), 0);

      // Streaming: one in, one out per cycle after the initial fill.
      do_reset();
      deq_ready = 1'b1;
      enq_valid = 1'b1;
      first   = -1;
      bubbles = 0;
      stalls  = 0;
      for (int c = 0; c < 200; c++) begin
         enq_bits = 8'(c);
         if (deq_valid) begin
            if (first < 0) first = c;
         end else if (first >= 0) begin
            bubbles++;
         end
         if (!enq_ready) stalls++;
         tick();
      end
      enq_valid = 1'b0;
      repeat (12) tick();
      check("stream_first_valid", first, 3);
      check("stream_bubbles", bubbles, 0);
      check("stream_enq_stalls", stalls, 0);
      check("stream_drained_count", int'(count), 0);

      // Random valid/ready.
      do_reset();
      start = n_deq;
      for (int c = 0; c < 40000 && (n_deq - start) < 5000; c++) begin
         enq_valid = 1'($urandom_range(0, 1));
         enq_bits  = 8'($urandom);
         deq_ready = 1'($urandom_range(0, 1));
         tick();
      end
      check("random_transfers_done", int'((n_deq - start) >= 5000), 1);
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      repeat (15) tick();
      check("random_drained_count", int'(count), 0);

      // Full FIFO with producer and consumer both active.
      do_reset();
      enq_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         enq_bits = 8'(100 + c);
         tick();
      end
      check("full_count", int'(count), CAP);
      check("full_enq_ready", int'(enq_ready), 0);
      enq_bits  = 8'hEE;
      deq_ready = 1'b1;
      check("full_s0_enq_ready", int'(enq_ready), 0);
      check("full_s0_deq_valid", int'(deq_valid), 1);
      tick();
      check("full_s1_enq_ready", int'(enq_ready), 1);
      misses = 0;
      for (int c = 0; c < 30; c++) begin
         enq_bits = 8'(200 + c);
         if (!deq_valid) misses++;
         tick();
      end
      check("full_deq_misses", misses, 0);
      enq_valid = 1'b0;
      repeat (15) tick();
      check("full_drained_count", int'(count), 0);

      // Reset while entries are stored and a read is in flight.
      do_reset();
      enq_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         enq_bits = 8'(50 + c);
         tick();
      end
      enq_valid = 1'b0;
      repeat (4) tick();
      deq_ready = 1'b1;
      tick();
      deq_ready = 1'b0;
      check("midrst_pre_count", int'(count), 5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("midrst_deq_valid", int'(deq_valid), 0);
      check("midrst_count", int'(count), 0);
      enq_valid = 1'b1;
      enq_bits  = 8'h3C;
      tick();
      enq_valid = 1'b0;
      check("midrst_p1_valid", int'(deq_valid), 0);
      tick();
      check("midrst_p2_valid", int'(deq_valid), 0);
      tick();
      check("midrst_p3_valid", int'(deq_valid), 1);
      check("midrst_p3_bits", int'(deq_bits), 'h3C);
      deq_ready = 1'b1;
      tick();
      deq_ready = 1'b0;
      check("midrst_final_count", int'(count), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
